// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Splits a CPU byte/word (8/16-bit) load or store into one or two cycles on
//   a byte-wide data memory. Word accesses are little-endian: the low byte is
//   at base and the high byte at base+1, with the address wrapping.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only when idle)
//   req_we, req_word          1=store/0=load, 1=16-bit/0=8-bit
//   req_addr, req_wdata       byte address, store data (byte uses [7:0])
//   resp_valid, resp_rdata    completion pulse, load result (held)
//   mem_en, mem_we            data memory enable / write enable
//   mem_addr, mem_din         data memory byte address / write byte
//   mem_dout                  data memory read byte (combinational)
module mem_access_unit #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_word,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [15:0]       req_wdata,
   output logic              resp_valid,
   output logic [15:0]       resp_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_din,
   input  logic [7:0]        mem_dout
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LO   = 2'd1;
   localparam logic [1:0] S_HI   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   typedef struct packed {
      logic              we;
      logic              word;
      logic [ADDR_W-1:0] addr;
      logic [15:0]       wdata;
   } req_t;

   logic [1:0]  state;
   req_t        cap;
   logic [15:0] rdata;

   assign req_ready  = (state == S_IDLE);
   assign resp_valid = (state == S_DONE);
   assign resp_rdata = rdata;

   // Enable and write enable are masked by rst so that a reset arriving
   // mid-access suppresses the memory write on that same edge; otherwise the
   // aborted cycle would still land in memory.
   always_comb begin
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = 8'h00;
      case (state)
         S_LO: begin
            mem_en   = ~rst;
            mem_we   = cap.we & ~rst;
            mem_addr = cap.addr;
            mem_din  = cap.wdata[7:0];
         end
         S_HI: begin
            mem_en   = ~rst;
            mem_we   = cap.we & ~rst;
            mem_addr = cap.addr + ADDR_W'(1);
            mem_din  = cap.wdata[15:8];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cap   <= '0;
         rdata <= 16'h0000;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  cap   <= '{we: req_we, word: req_word, addr: req_addr, wdata: req_wdata};
                  state <= S_LO;
               end
            end
            S_LO: begin
               if (!cap.we) begin
                  rdata[7:0] <= mem_dout;
                  // byte loads zero-extend
                  if (!cap.word) rdata[15:8] <= 8'h00;
               end
               state <= cap.word ? S_HI : S_DONE;
            end
            S_HI: begin
               if (!cap.we) rdata[15:8] <= mem_dout;
               state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic        req_word;
   logic [3:0]  req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_addr;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;

   int errors = 0;
   int checks = 0;

   logic [7:0]  mem [16];   // memory device attached to the unit
   logic [7:0]  sh  [16];   // expected memory contents
   logic [15:0] model_rdata;
   logic [15:0] exp_q [$];
   int          wr_cnt = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_word(req_word),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   assign mem_dout = mem_en ? mem[mem_addr] : 8'h00;

   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         mem[mem_addr] = mem_din;
         wr_cnt = wr_cnt + 1;
      end
   end

   // One access: scoreboard push on drive, per-cycle bus checks, pop on resp.
   task automatic run_access(input logic we, input logic word, input logic [3:0] addr,
                             input logic [15:0] wdata, input bit hold);
      logic [15:0] exp;
      logic [15:0] got;
      logic [3:0]  a1;
      logic [16:0] obs_bus;
      logic [16:0] exp_bus;
      int k;
      bit seen;
      a1 = addr + 4'd1;
      if (we) begin
         sh[addr] = wdata[7:0];
         if (word) sh[a1] = wdata[15:8];
         exp = model_rdata;
      end else begin
         exp = word ? {sh[a1], sh[addr]} : {8'h00, sh[addr]};
      end
      model_rdata = exp;
      exp_q.push_back(exp);

      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_word = word; req_addr = addr; req_wdata = wdata;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL ready_idle: got %b want 1", req_ready);
      end
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      k = 1; seen = 0;
      while (!seen && k <= 6) begin
         obs_bus = {mem_en, mem_we, mem_addr, mem_din, req_ready, resp_valid};
         if (k == 1) begin
            exp_bus = {1'b1, we, addr, wdata[7:0], 1'b0, 1'b0};
            checks++;
            if (obs_bus !== exp_bus) begin
               errors++; $display("FAIL lo_bus a=%h: got %h want %h", addr, obs_bus, exp_bus);
            end
         end else if (k == 2 && word) begin
            exp_bus = {1'b1, we, a1, wdata[15:8], 1'b0, 1'b0};
            checks++;
            if (obs_bus !== exp_bus) begin
               errors++; $display("FAIL hi_bus a=%h: got %h want %h", addr, obs_bus, exp_bus);
            end
         end
         if (resp_valid === 1'b1) begin
            seen = 1;
            checks++;
            if (k != (word ? 3 : 2)) begin
               errors++; $display("FAIL latency: got %0d want %0d", k, word ? 3 : 2);
            end
            exp_bus = 17'h00002;
            checks++;
            if (obs_bus !== {exp_bus[16:2], 1'b0, 1'b1}) begin
               errors++; $display("FAIL done_bus: got %h want %h", obs_bus, 17'h00001);
            end
            got = resp_rdata;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL sb_empty: got resp %h want none", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  errors++; $display("FAIL rdata a=%h we=%b w=%b: got %h want %h", addr, we, word, got, exp);
               end
            end
         end else begin
            @(negedge clk);
            k++;
         end
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL resp_timeout: got none want resp_valid");
         void'(exp_q.pop_front());
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] obs;
      rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_word = 1'b1;
      req_addr = 4'h3; req_wdata = 16'h5A5A;
      repeat (2) @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;
      obs = {req_ready, resp_valid, mem_en, mem_we, mem_addr, mem_din, resp_rdata};
      checks++;
      if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 16'h0000}) begin
         errors++; $display("FAIL reset_state: got %h want %h", obs, 32'h80000000);
      end
      @(negedge clk);
      checks++;
      if ({req_ready, mem_en, wr_cnt[0]} !== 3'b100) begin
         errors++; $display("FAIL reset_no_accept: got ready=%b en=%b wr=%0d want 1 0 0", req_ready, mem_en, wr_cnt);
      end
   endtask

   task automatic test_word_store();
      int w0;
      w0 = wr_cnt;
      run_access(1'b1, 1'b1, 4'h4, 16'hBEEF, 0);
      checks++;
      if ({mem[4], mem[5]} !== 16'hEFBE || wr_cnt - w0 != 2) begin
         errors++; $display("FAIL word_store_mem: got %h%h wr=%0d want efbe wr=2", mem[4], mem[5], wr_cnt - w0);
      end
   endtask

   task automatic test_loads();
      run_access(1'b0, 1'b1, 4'h4, 16'h0000, 0);   // 0xBEEF
      run_access(1'b0, 1'b0, 4'h5, 16'hFFFF, 0);   // 0x00BE
   endtask

   task automatic test_byte_store();
      logic [7:0] m7;
      m7 = mem[7];
      run_access(1'b1, 1'b0, 4'h6, 16'h1277, 0);   // rdata must stay 0x00BE
      checks++;
      if ({mem[6], mem[7]} !== {8'h77, m7}) begin
         errors++; $display("FAIL byte_store_mem: got %h%h want 77%h", mem[6], mem[7], m7);
      end
   endtask

   task automatic test_wrap();
      run_access(1'b1, 1'b1, 4'hF, 16'h1234, 0);
      checks++;
      if ({mem[15], mem[0]} !== 16'h3412) begin
         errors++; $display("FAIL wrap_mem: got %h%h want 3412", mem[15], mem[0]);
      end
      run_access(1'b0, 1'b1, 4'hF, 16'h0000, 0);
   endtask

   task automatic test_back_to_back();
      int w0;
      w0 = wr_cnt;
      run_access(1'b1, 1'b1, 4'hA, 16'hC3D4, 1);
      checks++;
      if (wr_cnt - w0 != 2) begin
         errors++; $display("FAIL held_valid_writes: got %0d want 2", wr_cnt - w0);
      end
      run_access(1'b0, 1'b1, 4'hA, 16'h0000, 1);
      for (int i = 0; i < 12; i++)
         run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
   endtask

   task automatic test_abort();
      int w0;
      logic [7:0] m9;
      logic [31:0] obs;
      bit extra;
      m9 = mem[9];
      w0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_word = 1'b1; req_addr = 4'h8; req_wdata = 16'hAAAA;
      @(negedge clk);
      req_valid = 1'b0;                            // LO
      @(negedge clk);                              // HI
      checks++;
      if ({mem_en, mem_addr} !== 5'h19) begin
         errors++; $display("FAIL abort_hi_bus: got en=%b a=%h want 1 9", mem_en, mem_addr);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_rdata = 16'h0000;
      obs = {req_ready, resp_valid, mem_en, mem_we, mem_addr, mem_din, resp_rdata};
      checks++;
      if (obs !== 32'h80000000) begin
         errors++; $display("FAIL abort_state: got %h want %h", obs, 32'h80000000);
      end
      checks++;
      if ({mem[8], mem[9]} !== {8'hAA, m9} || wr_cnt - w0 != 1) begin
         errors++; $display("FAIL abort_mem: got %h%h wr=%0d want aa%h wr=1", mem[8], mem[9], wr_cnt - w0, m9);
      end
      sh[8] = 8'hAA;
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid !== 1'b0) extra = 1;
      end
      checks++;
      if (extra) begin
         errors++; $display("FAIL abort_resp: got resp_valid=1 want 0");
      end
      run_access(1'b0, 1'b1, 4'h8, 16'h0000, 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem[i] = 8'(i * 17) ^ 8'h5A;
         sh[i]  = mem[i];
      end
      model_rdata = 16'h0000;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_word = 1'b0;
      req_addr = 4'h0; req_wdata = 16'h0000;
      test_reset();
      test_word_store();
      test_loads();
      test_byte_store();
      test_wrap();
      test_back_to_back();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
